// File: rtl/ldlt_pkg.sv
// Shared definitions for the LDL^T result receiver: FSM state encoding and
// helpers that derive the matrix dimension and packed lower-triangle size.
package ldlt_pkg;

  // Capture FSM states (also exported on the debug state port)
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RECV = 2'd1,
    S_DONE = 2'd2
  } ldlt_state_e;

  // Matrix dimension: six degrees of freedom per node
  function automatic int calc_n(input int node_num);
    return 6 * node_num;
  endfunction

  // Number of words in a packed lower triangle (diagonal included)
  function automatic int calc_l_size(input int n);
    return (n * (n + 1)) / 2;
  endfunction

endpackage

// File: rtl/ldlt_result_rx_tri_buf.sv
// tri_buf: packed lower-triangle storage, one write port and one registered
// read port. Storage is not reset; only the read register is.
module tri_buf
  import ldlt_pkg::*;
#(
  parameter int DATA_LEN = 32,
  parameter int L_SIZE   = 21,
  parameter int ADDR_W   = 5
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_wr_en,
  input  logic [ADDR_W-1:0]          i_wr_addr,
  input  logic signed [DATA_LEN-1:0] i_wr_data,
  input  logic                       i_rd_en,
  input  logic [ADDR_W-1:0]          i_rd_addr,
  output logic signed [DATA_LEN-1:0] o_rd_data
);

  logic signed [DATA_LEN-1:0] r_mem [L_SIZE];
  logic signed [DATA_LEN-1:0] r_rd_data;

  // Write port: storage keeps whatever was last written, reset or not
  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  // Read port: registered, holds when not enabled; a same-cycle write to the
  // same address is not visible until the following read
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_data <= '0;
    end else if (i_rd_en) begin
      r_rd_data <= r_mem[i_rd_addr];
    end
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/ldlt_result_rx.sv
// ldlt_result_rx: captures one LDL^T factor frame (packed lower triangle,
// row-major) from the factorizer stream into tri_buf and serves host reads
// addressed by (row, col).
//
// Stream handshake: there is no back-pressure. Every cycle with i_valid=1
// carries exactly one word and it is always accepted. A frame is L_SIZE
// consecutive valid cycles; a valid gap inside a frame truncates it.
module ldlt_result_rx
  import ldlt_pkg::*;
#(
  parameter int DATA_LEN = 32,
  parameter int NODE_NUM = 1,
  parameter int FRACTION = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_valid,
  input  logic signed [DATA_LEN-1:0] i_data,
  output logic                       o_busy,
  output logic                       o_done,
  output logic                       o_error,
  output logic                       o_diag_flag,
  input  logic                       i_rd_en,
  input  logic [$clog2(calc_n(NODE_NUM))-1:0] i_rd_row,
  input  logic [$clog2(calc_n(NODE_NUM))-1:0] i_rd_col,
  output logic                       o_rd_valid,
  output logic signed [DATA_LEN-1:0] o_rd_data,
  output logic [1:0]                 o_dbg_state
);

  localparam int N      = calc_n(NODE_NUM);
  localparam int L_SIZE = calc_l_size(N);
  localparam int IDX_W  = $clog2(N);
  localparam int ADDR_W = $clog2(L_SIZE);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);
  localparam logic [IDX_W:0]   N_W      = (IDX_W + 1)'(N);

  // FSM and write-side state
  ldlt_state_e       r_state;
  ldlt_state_e       w_next_state;
  logic              w_accept;
  logic              w_start;
  logic              w_trunc;
  logic              w_wrap;
  logic              w_last;
  logic [IDX_W-1:0]  r_row;
  logic [IDX_W-1:0]  r_col;
  logic [ADDR_W-1:0] r_base;
  logic [ADDR_W-1:0] w_row_ext;
  logic [ADDR_W-1:0] w_col_ext;
  logic [ADDR_W-1:0] w_wr_addr;
  logic              r_error;
  logic              r_diag_flag;
  logic              w_nonpos;
  logic              w_diag_bad;

  // Read-side signals
  logic              w_rd_hit;
  logic [ADDR_W:0]   w_rd_row_x;
  logic [ADDR_W:0]   w_rd_col_x;
  logic [ADDR_W-1:0] w_rd_addr;
  logic              r_rd_valid;
  logic              r_rd_zero;
  logic signed [DATA_LEN-1:0] w_buf_rd;

  // Position decode: diagonal word ends a row, (N-1,N-1) ends the frame
  assign w_wrap = (r_col == r_row);
  assign w_last = w_wrap && (r_row == LAST_IDX);

  // A word is <= 0 when negative, or when integer and fraction parts are zero
  assign w_nonpos   = i_data[DATA_LEN-1] |
                      ((i_data[DATA_LEN-1:FRACTION] == '0) && (i_data[FRACTION-1:0] == '0));
  assign w_diag_bad = w_wrap && w_nonpos;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state and per-cycle control; the first word of a frame is captured
  // in the same cycle the FSM leaves IDLE/DONE
  always_comb begin
    w_next_state = r_state;
    w_accept     = 1'b0;
    w_start      = 1'b0;
    w_trunc      = 1'b0;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (i_valid) begin
          w_next_state = S_RECV;
          w_accept     = 1'b1;
          w_start      = 1'b1;
        end else begin
          w_next_state = S_IDLE;
        end
      end
      S_RECV: begin
        if (i_valid) begin
          w_accept = 1'b1;
          if (w_last) begin
            w_next_state = S_DONE;
          end
        end else begin
          w_trunc      = 1'b1;
          w_next_state = S_IDLE;
        end
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // Write address is a running row base plus column, no multiply needed
  assign w_row_ext = {{(ADDR_W - IDX_W){1'b0}}, r_row};
  assign w_col_ext = {{(ADDR_W - IDX_W){1'b0}}, r_col};
  assign w_wr_addr = r_base + w_col_ext;

  // Row/col/base counters: cleared whenever the FSM leaves RECV so every
  // frame starts at (0,0), address 0
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_row  <= '0;
      r_col  <= '0;
      r_base <= '0;
    end else if (w_trunc || (w_accept && w_last)) begin
      r_row  <= '0;
      r_col  <= '0;
      r_base <= '0;
    end else if (w_accept) begin
      if (w_wrap) begin
        r_col  <= '0;
        r_row  <= r_row + IDX_W'(1);
        r_base <= r_base + w_row_ext + ADDR_W'(1);
      end else begin
        r_col  <= r_col + IDX_W'(1);
      end
    end
  end

  // Sticky status flags, cleared when a new frame starts; the first word is
  // itself a diagonal word so its check folds into the clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_error     <= 1'b0;
      r_diag_flag <= 1'b0;
    end else if (w_start) begin
      r_error     <= 1'b0;
      r_diag_flag <= w_diag_bad;
    end else begin
      if (w_trunc) begin
        r_error <= 1'b1;
      end
      if (w_accept && w_diag_bad) begin
        r_diag_flag <= 1'b1;
      end
    end
  end

  // Host read decode: only in-range lower-triangle positions hit storage
  assign w_rd_hit   = ({1'b0, i_rd_row} < N_W) && ({1'b0, i_rd_col} < N_W) &&
                      (i_rd_col <= i_rd_row);
  assign w_rd_row_x = {{(ADDR_W + 1 - IDX_W){1'b0}}, i_rd_row};
  assign w_rd_col_x = {{(ADDR_W + 1 - IDX_W){1'b0}}, i_rd_col};
  assign w_rd_addr  = w_rd_hit ?
                      ADDR_W'(((w_rd_row_x * (w_rd_row_x + (ADDR_W + 1)'(1))) >> 1) + w_rd_col_x) :
                      '0;

  // Read response qualifiers: valid follows enable by one cycle, the zero
  // select is captured alongside the storage read so both hold together
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_valid <= 1'b0;
      r_rd_zero  <= 1'b1;
    end else begin
      r_rd_valid <= i_rd_en;
      if (i_rd_en) begin
        r_rd_zero <= ~w_rd_hit;
      end
    end
  end

  tri_buf #(
    .DATA_LEN (DATA_LEN),
    .L_SIZE   (L_SIZE),
    .ADDR_W   (ADDR_W)
  ) u_tri_buf (
    .clk       (clk),
    .rst       (rst),
    .i_wr_en   (w_accept),
    .i_wr_addr (w_wr_addr),
    .i_wr_data (i_data),
    .i_rd_en   (i_rd_en),
    .i_rd_addr (w_rd_addr),
    .o_rd_data (w_buf_rd)
  );

  assign o_busy      = (r_state == S_RECV);
  assign o_done      = (r_state == S_DONE);
  assign o_error     = r_error;
  assign o_diag_flag = r_diag_flag;
  assign o_rd_valid  = r_rd_valid;
  assign o_rd_data   = r_rd_zero ? '0 : w_buf_rd;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_ldlt_result_rx.sv
// Directed bench for ldlt_result_rx: a NODE_NUM=1 instance (a_*) for frame,
// truncation, diagonal, reset and back-to-back cases, and a NODE_NUM=3
// instance (b_*) for a full 18x18 golden readback.
module tb_ldlt_result_rx;

  // Clock/reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Instance A: NODE_NUM=1 (N=6, 21 words)
  logic               a_valid;
  logic signed [31:0] a_data;
  logic               a_busy, a_done, a_error, a_diag;
  logic               a_rd_en;
  logic [2:0]         a_rd_row, a_rd_col;
  logic               a_rd_valid;
  logic signed [31:0] a_rd_data;
  logic [1:0]         a_state;

  // Instance B: NODE_NUM=3 (N=18, 171 words)
  logic               b_valid;
  logic signed [31:0] b_data;
  logic               b_busy, b_done, b_error, b_diag;
  logic               b_rd_en;
  logic [4:0]         b_rd_row, b_rd_col;
  logic               b_rd_valid;
  logic signed [31:0] b_rd_data;
  logic [1:0]         b_state;

  int errors = 0;
  int checks = 0;
  logic signed [31:0] golden [171];

  ldlt_result_rx #(.DATA_LEN(32), .NODE_NUM(1), .FRACTION(16)) u_dut_a (
    .clk(clk), .rst(rst), .i_valid(a_valid), .i_data(a_data),
    .o_busy(a_busy), .o_done(a_done), .o_error(a_error), .o_diag_flag(a_diag),
    .i_rd_en(a_rd_en), .i_rd_row(a_rd_row), .i_rd_col(a_rd_col),
    .o_rd_valid(a_rd_valid), .o_rd_data(a_rd_data), .o_dbg_state(a_state)
  );

  ldlt_result_rx #(.DATA_LEN(32), .NODE_NUM(3), .FRACTION(16)) u_dut_b (
    .clk(clk), .rst(rst), .i_valid(b_valid), .i_data(b_data),
    .o_busy(b_busy), .o_done(b_done), .o_error(b_error), .o_diag_flag(b_diag),
    .i_rd_en(b_rd_en), .i_rd_row(b_rd_row), .i_rd_col(b_rd_col),
    .o_rd_valid(b_rd_valid), .o_rd_data(b_rd_data), .o_dbg_state(b_state)
  );

  // Scoreboard comparison
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic a_word(input logic signed [31:0] d);
    a_valid = 1'b1;
    a_data  = d;
    step();
  endtask

  // Full 21-word frame: word k (1-based) = base+k, with optional zero/-5 override
  task automatic a_frame(input int base, input int zero_idx, input int neg_idx, input string tag);
    for (int k = 1; k <= 21; k++) begin
      if (k - 1 == zero_idx)     a_word(32'sd0);
      else if (k - 1 == neg_idx) a_word(-32'sd5);
      else                       a_word(base + k);
      if (k == 20) chk({tag, "_nodone"}, 32'(a_done), 32'd0);
    end
    chk({tag, "_done"}, 32'(a_done), 32'd1);
  endtask

  task automatic a_read(input logic [2:0] r, input logic [2:0] c, input logic signed [31:0] exp,
                        input string tag);
    a_rd_en  = 1'b1;
    a_rd_row = r;
    a_rd_col = c;
    step();
    chk({tag, "_vld"}, 32'(a_rd_valid), 32'd1);
    chk(tag, a_rd_data, exp);
    a_rd_en = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    a_valid = 1'b0; a_data = '0; a_rd_en = 1'b0; a_rd_row = '0; a_rd_col = '0;
    b_valid = 1'b0; b_data = '0; b_rd_en = 1'b0; b_rd_row = '0; b_rd_col = '0;
    for (int k = 0; k < 171; k++) golden[k] = k * 1001 - 50000;
    step();
    step();

    // Reset state
    chk("rst_busy",  32'(a_busy),     32'd0);
    chk("rst_done",  32'(a_done),     32'd0);
    chk("rst_error", 32'(a_error),    32'd0);
    chk("rst_diag",  32'(a_diag),     32'd0);
    chk("rst_rdvld", 32'(a_rd_valid), 32'd0);
    chk("rst_rdata", a_rd_data,       32'd0);
    chk("rst_state", 32'(a_state),    32'd0);
    chk("rst_b_busy", 32'(b_busy),    32'd0);
    rst = 1'b0;
    step();

    // Frame of 1..21: done visible in the cycle after the 21st word
    for (int k = 1; k <= 21; k++) begin
      a_word(k);
      if (k == 1)  chk("t1_busy_first", 32'(a_busy), 32'd1);
      if (k == 20) chk("t1_nodone_20",  32'(a_done), 32'd0);
    end
    chk("t1_done",  32'(a_done),  32'd1);
    chk("t1_busy",  32'(a_busy),  32'd0);
    chk("t1_state", 32'(a_state), 32'd2);
    chk("t1_diag",  32'(a_diag),  32'd0);
    chk("t1_error", 32'(a_error), 32'd0);
    a_valid = 1'b0;
    step();
    chk("t1_done_pulse", 32'(a_done),  32'd0);
    chk("t1_idle",       32'(a_state), 32'd0);
    a_read(3'd0, 3'd0, 32'sd1,  "t1_rd00");
    a_read(3'd1, 3'd3, 32'sd0,  "t1_rd13_upper");
    a_read(3'd6, 3'd0, 32'sd0,  "t1_rd60_oor");
    a_read(3'd7, 3'd7, 32'sd0,  "t1_rd77_oor");
    a_read(3'd5, 3'd5, 32'sd21, "t1_rd55");
    a_read(3'd2, 3'd1, 32'sd5,  "t1_rd21");
    step();
    chk("t1_rd_idle_vld",  32'(a_rd_valid), 32'd0);
    chk("t1_rd_hold",      a_rd_data,       32'sd5);

    // Truncation after 10 words, then recovery
    for (int k = 1; k <= 10; k++) a_word(100 + k);
    chk("t2_busy", 32'(a_busy), 32'd1);
    a_valid = 1'b0;
    step();
    chk("t2_error", 32'(a_error), 32'd1);
    chk("t2_nodone", 32'(a_done), 32'd0);
    chk("t2_state", 32'(a_state), 32'd0);
    chk("t2_busy_lo", 32'(a_busy), 32'd0);
    step();
    chk("t2_error_sticky", 32'(a_error), 32'd1);
    a_read(3'd3, 3'd0, 32'sd107, "t2_rd30_partial");
    a_read(3'd3, 3'd3, 32'sd110, "t2_rd33_partial");
    a_read(3'd4, 3'd0, 32'sd11,  "t2_rd40_old");
    a_word(32'sd1);
    chk("t2_err_cleared", 32'(a_error), 32'd0);
    for (int k = 2; k <= 21; k++) a_word(k);
    chk("t2_done", 32'(a_done), 32'd1);
    a_valid = 1'b0;
    step();

    // Diagonal checks: (3,3)=0 flags; non-positive off-diagonal does not;
    // negative (4,4) flags
    a_frame(0, 9, -1, "t3a");
    chk("t3a_diag", 32'(a_diag), 32'd1);
    a_valid = 1'b0;
    step();
    chk("t3a_diag_sticky", 32'(a_diag), 32'd1);
    a_frame(0, 3, 1, "t3b");
    chk("t3b_diag_clear", 32'(a_diag), 32'd0);
    a_valid = 1'b0;
    step();
    a_frame(0, -1, 14, "t3c");
    chk("t3c_diag_neg", 32'(a_diag), 32'd1);
    a_valid = 1'b0;
    step();

    // Reset at word 7
    a_read(3'd5, 3'd5, 32'sd21, "t4_pre_rd");
    for (int k = 1; k <= 6; k++) begin
      if (k == 6) begin
        a_rd_en = 1'b1; a_rd_row = 3'd0; a_rd_col = 3'd0;
      end
      a_word((k == 3) ? 32'sd0 : 400 + k);
    end
    chk("t4_pre_diag", 32'(a_diag), 32'd1);
    chk("t4_pre_rd00", a_rd_data, 32'sd401);
    a_data = 32'sd407;
    rst = 1'b1;
    #1;
    chk("t4_busy",  32'(a_busy),     32'd0);
    chk("t4_done",  32'(a_done),     32'd0);
    chk("t4_error", 32'(a_error),    32'd0);
    chk("t4_diag",  32'(a_diag),     32'd0);
    chk("t4_rdvld", 32'(a_rd_valid), 32'd0);
    chk("t4_rdata", a_rd_data,       32'd0);
    chk("t4_state", 32'(a_state),    32'd0);
    a_rd_en = 1'b0;
    a_valid = 1'b0;
    step();
    rst = 1'b0;
    step();
    a_frame(50, -1, -1, "t4_fresh");
    a_valid = 1'b0;
    step();
    a_read(3'd0, 3'd0, 32'sd51, "t4_rd00");
    a_read(3'd5, 3'd5, 32'sd71, "t4_rd55");
    a_read(3'd3, 3'd2, 32'sd59, "t4_rd32");

    // Back-to-back frames; read of address 0 while it is being rewritten
    a_frame(200, -1, -1, "t5a");
    for (int k = 1; k <= 21; k++) begin
      a_rd_en  = (k == 1);
      a_rd_row = 3'd0;
      a_rd_col = 3'd0;
      a_word(300 + k);
      if (k == 1) begin
        chk("t5_done_drop", 32'(a_done), 32'd0);
        chk("t5_busy",      32'(a_busy), 32'd1);
        chk("t5_rdw_old",   a_rd_data,   32'sd201);
      end
    end
    a_rd_en = 1'b0;
    chk("t5b_done", 32'(a_done), 32'd1);
    a_valid = 1'b0;
    step();
    a_read(3'd5, 3'd5, 32'sd321, "t5_rd55");
    a_read(3'd4, 3'd2, 32'sd313, "t5_rd42");
    a_read(3'd0, 3'd0, 32'sd301, "t5_rd00");

    // NODE_NUM=3 golden frame and full readback
    for (int k = 0; k < 171; k++) begin
      b_valid = 1'b1;
      b_data  = golden[k];
      step();
    end
    chk("t6_done", 32'(b_done), 32'd1);
    chk("t6_diag", 32'(b_diag), 32'd1);
    b_valid = 1'b0;
    step();
    for (int r = 0; r < 18; r++) begin
      for (int c = 0; c <= r; c++) begin
        b_rd_en  = 1'b1;
        b_rd_row = 5'(r);
        b_rd_col = 5'(c);
        step();
        chk($sformatf("t6_rd_%0d_%0d", r, c), b_rd_data, golden[(r * (r + 1)) / 2 + c]);
      end
    end
    b_rd_row = 5'd2;  b_rd_col = 5'd5;  step();
    chk("t6_rd_upper", b_rd_data, 32'd0);
    b_rd_row = 5'd18; b_rd_col = 5'd0;  step();
    chk("t6_rd_oor18", b_rd_data, 32'd0);
    b_rd_row = 5'd17; b_rd_col = 5'd17; step();
    chk("t6_rd_last", b_rd_data, golden[170]);
    b_rd_en = 1'b0;
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
